branch_predict_unit: RTL

//  Parametrised successor to the combinational branch resolver. Adds a direct-mapped BTB

---
 rtl/branch_predict_unit_pkg.sv | 21 ++
 rtl/branch_compare.sv | 48 ++++
 rtl/branch_predict_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/branch_predict_unit_pkg.sv
// rtl/branch_predict_unit_pkg.sv - opcode and branch condition codes shared by the branch predict unit
package branch_predict_unit_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_func_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
    return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/branch_compare.sv
// rtl/branch_compare.sv - combinational control-transfer resolver: actual direction and target
module branch_compare
  import branch_predict_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [6:0]      opcode,
  input  logic [2:0]      func_3,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs_1,
  input  logic [XLEN-1:0] rs_2,
  output logic            is_xfer,
  output logic            taken,
  output logic [XLEN-1:0] target
);

  always_comb begin
    is_xfer = 1'b0;
    taken   = 1'b0;
    target  = pc + imm;
    case (opcode)
      OP_JAL: begin
        is_xfer = 1'b1;
        taken   = 1'b1;
      end
      OP_JALR: begin
        is_xfer = 1'b1;
        taken   = 1'b1;
        // only bit 0 is cleared; the full-width sum is kept
        target  = (rs_1 + imm) & {{(XLEN-1){1'b1}}, 1'b0};
      end
      OP_BRANCH: begin
        case (func_3)
          F3_BEQ:  begin is_xfer = 1'b1; taken = (rs_1 == rs_2); end
          F3_BNE:  begin is_xfer = 1'b1; taken = (rs_1 != rs_2); end
          F3_BLT:  begin is_xfer = 1'b1; taken = ($signed(rs_1) <  $signed(rs_2)); end
          F3_BGE:  begin is_xfer = 1'b1; taken = ($signed(rs_1) >= $signed(rs_2)); end
          F3_BLTU: begin is_xfer = 1'b1; taken = (rs_1 <  rs_2); end
          F3_BGEU: begin is_xfer = 1'b1; taken = (rs_1 >= rs_2); end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - direct-mapped BTB predictor with execute-stage resolution and redirect
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16,
  parameter int CTR_BITS    = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_f_valid,
  input  logic [XLEN-1:0] i_f_pc,
  output logic            o_f_pred_taken,
  output logic [XLEN-1:0] o_f_pred_pc,
  input  logic            i_r_valid,
  input  logic [XLEN-1:0] i_r_pc,
  input  logic [6:0]      i_r_opcode,
  input  logic [2:0]      i_r_func_3,
  input  logic [XLEN-1:0] i_r_imm,
  input  logic [XLEN-1:0] i_r_rs_1,
  input  logic [XLEN-1:0] i_r_rs_2,
  input  logic            i_r_pred_taken,
  input  logic [XLEN-1:0] i_r_pred_pc,
  output logic            o_res_valid,
  output logic            o_b_taken,
  output logic [XLEN-1:0] o_b_pc,
  output logic            o_mispredict,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic [31:0]     o_br_count,
  output logic [31:0]     o_mp_count
);

  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - CTR_BITS'(1);
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  logic                btb_valid  [BTB_ENTRIES];
  logic                btb_jump   [BTB_ENTRIES];
  logic [TAG_W-1:0]    btb_tag    [BTB_ENTRIES];
  logic [XLEN-1:0]     btb_target [BTB_ENTRIES];
  logic [CTR_BITS-1:0] btb_ctr    [BTB_ENTRIES];

  logic [IDX-1:0]   f_idx, r_idx;
  logic [TAG_W-1:0] f_tag, r_tag;
  logic             f_hit, r_hit;

  assign f_idx = i_f_pc[IDX+1:2];
  assign f_tag = i_f_pc[XLEN-1:IDX+2];
  assign f_hit = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);

  // reads the table before this edge's update, so same-index lookups see old contents
  assign o_f_pred_taken = i_f_valid && f_hit && (btb_jump[f_idx] || btb_ctr[f_idx][CTR_BITS-1]);
  assign o_f_pred_pc    = o_f_pred_taken ? btb_target[f_idx] : i_f_pc + XLEN'(4);

  assign r_idx = i_r_pc[IDX+1:2];
  assign r_tag = i_r_pc[XLEN-1:IDX+2];
  assign r_hit = btb_valid[r_idx] && (btb_tag[r_idx] == r_tag);

  logic            r_xfer, r_taken;
  logic [XLEN-1:0] r_target;

  branch_compare #(.XLEN(XLEN)) u_cmp (
    .opcode  (i_r_opcode),
    .func_3  (i_r_func_3),
    .pc      (i_r_pc),
    .imm     (i_r_imm),
    .rs_1    (i_r_rs_1),
    .rs_2    (i_r_rs_2),
    .is_xfer (r_xfer),
    .taken   (r_taken),
    .target  (r_target)
  );

  logic r_ctrl, r_mp;
  logic [CTR_BITS-1:0] ctr_next;

  assign r_ctrl = i_r_valid && r_xfer;
  assign r_mp   = r_ctrl && ((r_taken != i_r_pred_taken) || (r_taken && (r_target != i_r_pred_pc)));

  always_comb begin
    ctr_next = btb_ctr[r_idx];
    if (r_taken && btb_ctr[r_idx] != CTR_MAX)
      ctr_next = btb_ctr[r_idx] + CTR_BITS'(1);
    else if (!r_taken && btb_ctr[r_idx] != '0)
      ctr_next = btb_ctr[r_idx] - CTR_BITS'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_jump[i]   <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        btb_ctr[i]    <= CTR_WNT;
      end
      o_res_valid   <= 1'b0;
      o_b_taken     <= 1'b0;
      o_b_pc        <= '0;
      o_mispredict  <= 1'b0;
      o_redirect_pc <= '0;
      o_br_count    <= '0;
      o_mp_count    <= '0;
    end else begin
      o_res_valid   <= i_r_valid;
      o_b_taken     <= i_r_valid && r_taken;
      o_b_pc        <= r_ctrl ? r_target : '0;
      o_mispredict  <= r_mp;
      o_redirect_pc <= !i_r_valid ? '0 : (r_taken ? r_target : i_r_pc + XLEN'(4));
      o_br_count    <= sat_inc32(o_br_count, r_ctrl);
      o_mp_count    <= sat_inc32(o_mp_count, r_mp);
      if (r_ctrl) begin
        if (r_hit) begin
          btb_ctr[r_idx] <= ctr_next;
          if (r_taken) btb_target[r_idx] <= r_target;
        end else if (r_taken) begin
          btb_valid[r_idx]  <= 1'b1;
          btb_jump[r_idx]   <= (i_r_opcode == OP_JAL) || (i_r_opcode == OP_JALR);
          btb_tag[r_idx]    <= r_tag;
          btb_target[r_idx] <= r_target;
          btb_ctr[r_idx]    <= CTR_WT;
        end
      end
    end
  end

  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{i_f_pc[1:0], i_r_pc[1:0]};

endmodule
